// File: rtl/shift_add_mul_pkg.sv
// Shared definitions for the shift-and-add multiplier: controller state codes
// and the iteration count.
package shift_add_mul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int ITER  = 5;
   localparam int SUM_W = 5;

endpackage

// File: rtl/shift_add_mul_sum.sv
// The lab's 5-bit ripple-carry adder my_sum, built from a chain of bitsum
// full adders. Reused as-is by the multiplier.
module bitsum (
   input  logic a_i,
   input  logic b_i,
   input  logic ci_i,
   output logic s_o,
   output logic co_o
);

   assign s_o  = a_i ^ b_i ^ ci_i;
   assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));

endmodule

module my_sum
   import shift_add_mul_pkg::*;
(
   input  logic [SUM_W-1:0] Ain,
   input  logic [SUM_W-1:0] Bin,
   input  logic             Ci,
   output logic [SUM_W-1:0] Sout,
   output logic             Co
);

   logic [SUM_W:0] carry;

   assign carry[0] = Ci;

   for (genvar i = 0; i < SUM_W; i++) begin : g_bit
      bitsum u_bit (
         .a_i  (Ain[i]),
         .b_i  (Bin[i]),
         .ci_i (carry[i]),
         .s_o  (Sout[i]),
         .co_o (carry[i+1])
      );
   end

   assign Co = carry[SUM_W];

endmodule

// File: rtl/shift_add_mul.sv
// Sequential 5x5 unsigned multiplier: one add-and-shift step per cycle through
// my_sum, five steps, start/done handshake, product held until the next done.
module shift_add_mul
   import shift_add_mul_pkg::*;
#(
   parameter int WIDTH = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   // Handshake: start is sampled only in IDLE; busy is high from the cycle
   // after the accepted start through the done cycle; done pulses for one
   // cycle and product is valid from that cycle until the next done.

   state_e             state_q;
   logic [WIDTH-1:0]   m_q;
   logic [WIDTH-1:0]   acc_q;
   logic               c_q;
   logic [WIDTH-1:0]   q_q;
   logic [2:0]         cnt_q;
   logic               busy_q;
   logic               done_q;
   logic [2*WIDTH-1:0] product_q;

   logic [WIDTH-1:0]   add_b;
   logic [WIDTH-1:0]   sum;
   logic               co;
   logic               c_d;
   logic [WIDTH-1:0]   acc_d;
   logic [WIDTH-1:0]   q_d;

   assign add_b = q_q[0] ? m_q : '0;

   // C is cleared by every step, so the adder carry-in is always zero.
   my_sum u_sum (
      .Ain  (acc_q),
      .Bin  (add_b),
      .Ci   (c_q),
      .Sout (sum),
      .Co   (co)
   );

   always_comb begin
      {c_d, acc_d, q_d} = {1'b0, co, sum, q_q[WIDTH-1:1]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         m_q       <= '0;
         acc_q     <= '0;
         c_q       <= 1'b0;
         q_q       <= '0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         product_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  m_q     <= a;
                  q_q     <= b;
                  acc_q   <= '0;
                  c_q     <= 1'b0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= CALC;
               end
            end
            CALC: begin
               acc_q <= acc_d;
               q_q   <= q_d;
               c_q   <= c_d;
               cnt_q <= cnt_q + 3'd1;
               // Capturing the final step's result here makes product valid
               // in the same cycle done is seen.
               if (cnt_q == 3'(ITER - 1)) begin
                  product_q <= {acc_d, q_d};
                  done_q    <= 1'b1;
                  state_q   <= DONE;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign product = product_q;

endmodule

// File: tb/tb_shift_add_mul.sv
// Self-checking bench for shift_add_mul: directed handshake/reset cases, then
// all 1024 operand pairs back-to-back in shuffled order against a*b.
module tb_shift_add_mul;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [4:0] a;
   logic [4:0] b;
   logic       busy;
   logic       done;
   logic [9:0] product;

   int checks   = 0;
   int passes   = 0;
   int n_ops    = 0;
   int done_cnt = 0;

   localparam int EXP_LAT = 6;

   shift_add_mul #(.WIDTH(5)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (done === 1'b1) done_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   // One full multiply: start held across one edge, then wait for done.
   task automatic run_op(input logic [4:0] ai, input logic [4:0] bi);
      int   lat;
      int   bcnt;
      logic seen;
      start = 1'b1;
      a     = ai;
      b     = bi;
      tick();
      start = 1'b0;
      a     = 5'($urandom);
      b     = 5'($urandom);
      lat   = 1;
      bcnt  = (busy === 1'b1) ? 1 : 0;
      seen  = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (done === 1'b1) seen = 1'b1;
         else begin
            tick();
            lat++;
            if (busy === 1'b1) bcnt++;
         end
      end
      chk("product", 32'(product), 32'(int'(ai) * int'(bi)));
      chk("latency", 32'(lat), 32'(EXP_LAT));
      chk("busy_cycles", 32'(bcnt), 32'(EXP_LAT));
      n_ops++;
      tick();
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("busy_after_done", 32'(busy), 32'd0);
   endtask

   int order[1024];
   int tmp;
   int j;
   int seen_done;

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      tick();
      tick();
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_product", 32'(product), 32'd0);
      rst = 1'b0;
      tick();

      run_op(5'd13, 5'd11);
      run_op(5'd31, 5'd31);
      run_op(5'd0, 5'd31);
      run_op(5'd31, 5'd0);

      // Starts during CALC and during the done cycle must be ignored.
      start = 1'b1; a = 5'd5; b = 5'd7;
      tick();
      start = 1'b0;
      tick();
      start = 1'b1; a = 5'd31; b = 5'd31;
      tick();
      start = 1'b0;
      for (int i = 0; i < 20 && done !== 1'b1; i++) tick();
      chk("ignored_start_done", 32'(done), 32'd1);
      chk("ignored_start_product", 32'(product), 32'd35);
      n_ops++;
      start = 1'b1; a = 5'd3; b = 5'd3;
      tick();
      start = 1'b0;
      chk("done_cycle_start_busy", 32'(busy), 32'd0);
      tick();
      chk("no_queued_start", 32'(busy), 32'd0);
      chk("product_held", 32'(product), 32'd35);

      // Reset in the middle of CALC discards the operation.
      start = 1'b1; a = 5'd9; b = 5'd9;
      tick();
      start = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midreset_busy", 32'(busy), 32'd0);
      chk("midreset_done", 32'(done), 32'd0);
      chk("midreset_product", 32'(product), 32'd0);
      seen_done = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (done === 1'b1) seen_done++;
      end
      chk("midreset_no_done", 32'(seen_done), 32'd0);
      run_op(5'd1, 5'd31);

      // Reset wins over a simultaneous start.
      rst = 1'b1; start = 1'b1; a = 5'd7; b = 5'd7;
      tick();
      rst = 1'b0; start = 1'b0;
      chk("rst_start_busy", 32'(busy), 32'd0);
      tick();
      chk("rst_start_still_idle", 32'(busy), 32'd0);

      for (int i = 0; i < 1024; i++) order[i] = i;
      for (int i = 1023; i > 0; i--) begin
         j        = int'($urandom_range(i, 0));
         tmp      = order[i];
         order[i] = order[j];
         order[j] = tmp;
      end
      for (int i = 0; i < 1024; i++) begin
         run_op(5'(order[i] >> 5), 5'(order[i]));
      end

      tick();
      chk("done_pulse_count", 32'(done_cnt), 32'(n_ops));

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
